pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the 6-stage MIPS-style pipeline.
- Produces the 6-bit stall vector consumed by every pipeline register: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb (the wb register holds when bit5=1).
- Arbitrates the stall requests from id (load-use), ex (multi-cycle ops) and mem (bus wait).
- Sequences multi-cycle ex operations with an internal counter.
- Issues a registered one-cycle flush with a redirect PC on exceptions.

Parameters:
- MULTI_CYC, 32, number of cycles for one ex multi-cycle operation (div); legal range 2..63.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MULTI_CYC.
- TIMEOUT_CYC, 255, MEMWAIT watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- id_stallreq  in  1  load-use hazard, level.
- ex_multi_start  in  1  one-cycle pulse: ex begins a multi-cycle op.
- mem_req  in  1  mem stage issues a bus access this cycle.
- mem_ack  in  1  bus access completes.
- exc_flush  in  1  exception pulse from mem.
- exc_pc  in  32  exception vector, sampled with exc_flush.
- stall  out  6  stall vector, combinational from state and inputs.
- multi_done  out  1  one-cycle pulse: ex result valid.
- flush  out  1  registered flush pulse.
- new_pc  out  32  registered redirect PC.
- mem_timeout  out  1  watchdog pulse (optional feature).

Behaviour:
Stall encodings:
- none = 000000
- id = 000111
- ex = 001111
- mem = 011111
- Priority when several apply: mem > ex > id.

Reset:
- state=IDLE, cnt=0, pending=0.
- flush=0, new_pc=0, multi_done=0, mem_timeout=0.
- stall evaluates to 000000 while reset_n=0.

FSM states: IDLE, MULTI, MEMWAIT, FLUSH.

IDLE:
- exc_flush: go to FLUSH, latch exc_pc, stall=000000.
- Otherwise mem_req & !mem_ack: stall=mem, go to MEMWAIT.
- Otherwise ex_multi_start: stall=ex, cnt=MULTI_CYC-1, go to MULTI.
- Otherwise id_stallreq: stall=id.
- mem_req & mem_ack in the same cycle is zero-wait: no stall.

MULTI:
- Default stall=ex; cnt decrements each cycle.
- When cnt==0: multi_done=1, stall=none (id request still honoured), return to IDLE.
- mem_req & !mem_ack in MULTI: stall=mem for that cycle and cnt keeps counting.
  - If cnt==0 coincides with a mem stall, cnt holds at 0 and multi_done is deferred until the first cycle without a mem stall.
- exc_flush in MULTI: abort, no multi_done, go to FLUSH.

MEMWAIT:
- stall=mem until mem_ack.
- Ack cycle: stall=none; go to IDLE, or to FLUSH if pending=1.
- exc_flush during MEMWAIT is not taken immediately (the bus access must finish): set pending=1 and latch exc_pc.

FLUSH:
- flush=1 and new_pc=latched PC, registered and visible in this state.
- stall=000000.
- Exactly one cycle, then IDLE; pending cleared.
- Request inputs are ignored during FLUSH.

Flush timing and suppression:
- exc_flush at cycle T from IDLE or MULTI gives flush=1 at T+1.
- multi_done is never asserted in the same cycle as flush.
- A second exc_flush while pending=1 overwrites the latched PC.

Reset mid-operation:
- Immediate return to IDLE; the counter and pending are cleared; no stray multi_done or flush.

Optional Feature:
MEM_TIMEOUT_EN
- With it: a watchdog counts MEMWAIT cycles. At TIMEOUT_CYC it pulses mem_timeout for one cycle, drops stall to 000000, and goes to IDLE (or to FLUSH if pending=1). The counter clears on leaving MEMWAIT.
- Without it: MEMWAIT waits indefinitely and mem_timeout is tied to 0.

Decomposition:
- Shared package (pipe_pkg): state enum; the stall-vector constants STALL_NONE, STALL_ID, STALL_EX, STALL_MEM; stage bit indices.
- One sub-module, multi_cyc_cnt: load, decrement, hold and zero flag. It is reused by the watchdog.
- The FSM and stall priority mux stay in the top module.

Test Plan:
1. id_stallreq=1 for 2 cycles in IDLE -> stall=000111 for exactly those 2 cycles; multi_done=0; flush=0.
2. ex_multi_start pulse at T with MULTI_CYC=32 -> stall=001111 from T through T+31; multi_done=1 and stall=000000 at T+32.
3. mem_req=1 with mem_ack at T+3 -> stall=011111 at T..T+2, 000000 at T+3; with mem_ack at T, no stall.
4. MULTI with mem wait covering the cnt==0 cycle -> multi_done deferred to the first cycle after mem_ack; stall=011111 while waiting.
5. exc_flush with exc_pc=0x00000020 at MULTI cycle 5 -> flush=1 and new_pc=0x20 at the next cycle; multi_done never asserted. During MEMWAIT the same stimulus gives flush one cycle after mem_ack.
6. reset_n low mid-MULTI, then MEM_TIMEOUT_EN with mem_ack withheld -> after reset all outputs 0 and state IDLE; mem_timeout pulse after 255 MEMWAIT cycles; stall=000000 on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;
    localparam int STALL_W = STG_WB + 1;

    typedef logic [STALL_W-1:0] stall_t;

    // A stall from stage s holds that stage and every stage upstream of it.
    function automatic stall_t stall_upto(input int stg);
        stall_t m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) m[i] = (i <= stg);
        return m;
    endfunction

    localparam stall_t STALL_NONE = '0;
    localparam stall_t STALL_ID   = stall_upto(STG_ID);
    localparam stall_t STALL_EX   = stall_upto(STG_EX);
    localparam stall_t STALL_MEM  = stall_upto(STG_MEM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULTI,
        ST_MEMWAIT,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/multi_cyc_cnt.sv
// Loadable down-counter with zero flag; it saturates at zero rather than wrapping.
module multi_cyc_cnt
    import pipe_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: arbitrates id/ex/mem stall requests, sequences
// multi-cycle ex ops and issues a one-cycle flush. Optional MEMWAIT watchdog: MEM_TIMEOUT_EN.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULTI_CYC   = 32,
    parameter int CNT_W       = 6,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_stallreq_i,
    input  logic               ex_multi_start_i,
    input  logic               mem_req_i,
    input  logic               mem_ack_i,
    input  logic               exc_flush_i,
    input  logic [31:0]        exc_pc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               multi_done_o,
    output logic               flush_o,
    output logic [31:0]        new_pc_o,
    output logic               mem_timeout_o
);

    if (MULTI_CYC < 2 || MULTI_CYC > 63 || (1 << CNT_W) <= MULTI_CYC) begin : g_bad_multi
        $error("pipe_stall_ctrl: MULTI_CYC/CNT_W out of range");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("pipe_stall_ctrl: TIMEOUT_CYC must be positive");
    end

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q;
    logic [31:0] new_pc_q;
    stall_t      stall_sel;
    logic        mem_stall;
    logic        cnt_load, cnt_dec, cnt_clr, cnt_zero;
    logic        multi_done;
    logic        wd_fire;
    logic [CNT_W-1:0] cnt_val;

    assign mem_stall = mem_req_i & ~mem_ack_i;

    multi_cyc_cnt #(.W(CNT_W)) u_multi_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MULTI_CYC - 1)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic            wd_zero;
    logic [WD_W-1:0] wd_cnt;
    logic            in_mw, enter_mw, leave_mw;

    assign in_mw    = (state_q == ST_MEMWAIT);
    assign enter_mw = !in_mw && (state_d == ST_MEMWAIT);
    assign leave_mw = in_mw && (state_d != ST_MEMWAIT);

    // Loaded with the full limit on entry, so it hits zero after TIMEOUT_CYC waiting cycles.
    multi_cyc_cnt #(.W(WD_W)) u_wdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (leave_mw),
        .load_i     (enter_mw),
        .load_val_i (WD_W'(TIMEOUT_CYC)),
        .dec_i      (in_mw),
        .cnt_o      (wd_cnt),
        .zero_o     (wd_zero)
    );
    assign wd_fire = in_mw && wd_zero && !mem_ack_i;
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pc_d       = pc_q;
        stall_sel  = STALL_NONE;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clr    = 1'b0;
        multi_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_flush_i) begin
                    state_d = ST_FLUSH;
                    pc_d    = exc_pc_i;
                end else if (mem_stall) begin
                    stall_sel = STALL_MEM;
                    state_d   = ST_MEMWAIT;
                end else if (ex_multi_start_i) begin
                    stall_sel = STALL_EX;
                    cnt_load  = 1'b1;
                    state_d   = ST_MULTI;
                end else if (id_stallreq_i) begin
                    stall_sel = STALL_ID;
                end
            end
            ST_MULTI: begin
                cnt_dec = 1'b1;
                if (exc_flush_i) begin
                    cnt_clr = 1'b1;
                    pc_d    = exc_pc_i;
                    state_d = ST_FLUSH;
                end else if (mem_stall) begin
                    stall_sel = STALL_MEM;
                end else if (cnt_zero) begin
                    multi_done = 1'b1;
                    stall_sel  = id_stallreq_i ? STALL_ID : STALL_NONE;
                    state_d    = ST_IDLE;
                end else begin
                    stall_sel = STALL_EX;
                end
            end
            ST_MEMWAIT: begin
                // The bus access must complete, so an exception is only remembered here.
                if (exc_flush_i) begin
                    pend_d = 1'b1;
                    pc_d   = exc_pc_i;
                end
                if (mem_ack_i || wd_fire)
                    state_d = (pend_q || exc_flush_i) ? ST_FLUSH : ST_IDLE;
                else
                    stall_sel = STALL_MEM;
            end
            ST_FLUSH: begin
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            pc_q     <= '0;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            flush_q <= (state_d == ST_FLUSH);
            if (state_d == ST_FLUSH) new_pc_q <= pc_d;
        end
    end

    assign stall_o       = reset_n ? stall_sel : STALL_NONE;
    assign multi_done_o  = multi_done;
    assign flush_o       = flush_q;
    assign new_pc_o      = new_pc_q;
    assign mem_timeout_o = wd_fire;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed expectations (default parameters).
module tb_pipe_stall_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_stallreq, ex_multi_start, mem_req, mem_ack, exc_flush;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        multi_done, flush, mem_timeout;
    logic [31:0] new_pc;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stall_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_stallreq_i    (id_stallreq),
        .ex_multi_start_i (ex_multi_start),
        .mem_req_i        (mem_req),
        .mem_ack_i        (mem_ack),
        .exc_flush_i      (exc_flush),
        .exc_pc_i         (exc_pc),
        .stall_o          (stall),
        .multi_done_o     (multi_done),
        .flush_o          (flush),
        .new_pc_o         (new_pc),
        .mem_timeout_o    (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        id_stallreq = 0; ex_multi_start = 0; mem_req = 0; mem_ack = 0;
        exc_flush = 0; exc_pc = '0;
    endtask

    initial begin
        idle_in();
        reset_n = 0;
        id_stallreq = 1;
        #3;
        chk("rst_stall", stall, 6'b000000);
        chk("rst_flush", flush, 0);
        chk("rst_newpc", new_pc, 0);
        chk("rst_mdone", multi_done, 0);
        chk("rst_mto", mem_timeout, 0);
        cyc();
        reset_n = 1;
        id_stallreq = 0;

        // 1: load-use stall for two cycles
        id_stallreq = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t1_stall", stall, 6'b000111);
            chk("t1_mdone", multi_done, 0);
            chk("t1_flush", flush, 0);
            cyc();
        end
        id_stallreq = 0;
        settle();
        chk("t1_release", stall, 6'b000000);
        cyc();

        // 2: multi-cycle op, done at T+32
        ex_multi_start = 1;
        settle();
        chk("t2_start", stall, 6'b001111);
        cyc();
        ex_multi_start = 0;
        for (int k = 1; k < 32; k++) begin
            settle();
            chk("t2_busy", stall, 6'b001111);
            chk("t2_nodone", multi_done, 0);
            cyc();
        end
        settle();
        chk("t2_done", multi_done, 1);
        chk("t2_done_stall", stall, 6'b000000);
        cyc();
        settle();
        chk("t2_after", multi_done, 0);
        chk("t2_after_stall", stall, 6'b000000);
        cyc();

        // 3: bus wait of three cycles, then a zero-wait access
        mem_req = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_wait", stall, 6'b011111);
            cyc();
        end
        mem_ack = 1;
        settle();
        chk("t3_ack", stall, 6'b000000);
        cyc();
        mem_req = 0; mem_ack = 0;
        settle();
        chk("t3_idle", stall, 6'b000000);
        cyc();
        mem_req = 1; mem_ack = 1;
        settle();
        chk("t3_zw", stall, 6'b000000);
        cyc();
        mem_req = 0; mem_ack = 0;
        id_stallreq = 1;
        settle();
        chk("t3_zw_idle", stall, 6'b000111);
        cyc();
        id_stallreq = 0;

        // 4: mem wait covering the cnt==0 cycle defers multi_done
        ex_multi_start = 1;
        settle();
        chk("t4_start", stall, 6'b001111);
        cyc();
        ex_multi_start = 0;
        for (int k = 1; k < 30; k++) begin
            settle();
            chk("t4_busy", stall, 6'b001111);
            cyc();
        end
        mem_req = 1;
        for (int k = 30; k < 34; k++) begin
            settle();
            chk("t4_memstall", stall, 6'b011111);
            chk("t4_defer", multi_done, 0);
            cyc();
        end
        mem_ack = 1;
        settle();
        chk("t4_done", multi_done, 1);
        chk("t4_done_stall", stall, 6'b000000);
        cyc();
        mem_req = 0; mem_ack = 0;
        settle();
        chk("t4_after", multi_done, 0);
        chk("t4_after_stall", stall, 6'b000000);
        cyc();

        // 5a: exception in MULTI cycle 5 aborts the op
        ex_multi_start = 1;
        cyc();
        ex_multi_start = 0;
        for (int k = 1; k < 5; k++) cyc();
        exc_flush = 1; exc_pc = 32'h0000_0020;
        settle();
        chk("t5a_exc_flush", flush, 0);
        chk("t5a_exc_mdone", multi_done, 0);
        cyc();
        exc_flush = 0; exc_pc = '0;
        id_stallreq = 1;
        settle();
        chk("t5a_flush", flush, 1);
        chk("t5a_newpc", new_pc, 32'h20);
        chk("t5a_flush_stall", stall, 6'b000000);
        chk("t5a_flush_mdone", multi_done, 0);
        cyc();
        settle();
        chk("t5a_flush_end", flush, 0);
        chk("t5a_idle", stall, 6'b000111);
        chk("t5a_pc_hold", new_pc, 32'h20);
        cyc();
        id_stallreq = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            chk("t5a_no_mdone", multi_done, 0);
            cyc();
        end

        // 5b: exception during a bus wait, overwritten once, taken after ack
        mem_req = 1;
        settle();
        chk("t5b_enter", stall, 6'b011111);
        cyc();
        exc_flush = 1; exc_pc = 32'h0000_0020;
        settle();
        chk("t5b_hold", stall, 6'b011111);
        chk("t5b_noflush", flush, 0);
        cyc();
        exc_pc = 32'h0000_0060;
        settle();
        chk("t5b_hold2", stall, 6'b011111);
        cyc();
        exc_flush = 0; exc_pc = '0; mem_ack = 1;
        settle();
        chk("t5b_ack", stall, 6'b000000);
        chk("t5b_ack_flush", flush, 0);
        cyc();
        mem_req = 0; mem_ack = 0; id_stallreq = 1;
        settle();
        chk("t5b_flush", flush, 1);
        chk("t5b_newpc", new_pc, 32'h60);
        chk("t5b_flush_stall", stall, 6'b000000);
        cyc();
        settle();
        chk("t5b_flush_end", flush, 0);
        chk("t5b_idle", stall, 6'b000111);
        cyc();
        id_stallreq = 0;

        // 6: reset mid-MULTI, then a withheld ack
        ex_multi_start = 1;
        cyc();
        ex_multi_start = 0;
        cyc(); cyc();
        reset_n = 0; id_stallreq = 1;
        settle();
        chk("t6_rst_stall", stall, 6'b000000);
        chk("t6_rst_flush", flush, 0);
        chk("t6_rst_mdone", multi_done, 0);
        cyc(); cyc();
        reset_n = 1; id_stallreq = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            chk("t6_post_stall", stall, 6'b000000);
            chk("t6_post_mdone", multi_done, 0);
            chk("t6_post_flush", flush, 0);
            cyc();
        end

        mem_req = 1;
        settle();
        chk("t6_mw_enter", stall, 6'b011111);
        cyc();
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k < 256; k++) begin
            settle();
            chk("t6_wd_wait", stall, 6'b011111);
            chk("t6_wd_quiet", mem_timeout, 0);
            cyc();
        end
        settle();
        chk("t6_wd_fire", mem_timeout, 1);
        chk("t6_wd_stall", stall, 6'b000000);
        cyc();
        mem_req = 0;
        settle();
        chk("t6_wd_after", mem_timeout, 0);
        chk("t6_wd_idle", stall, 6'b000000);
        cyc();
`else
        for (int k = 1; k < 300; k++) begin
            settle();
            chk("t6_nowd_wait", stall, 6'b011111);
            chk("t6_nowd_mto", mem_timeout, 0);
            cyc();
        end
        mem_ack = 1;
        settle();
        chk("t6_nowd_ack", stall, 6'b000000);
        cyc();
        mem_req = 0; mem_ack = 0;
        settle();
        chk("t6_nowd_idle", stall, 6'b000000);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
